// File: rtl/ex_stage_if.sv
// Bundle between the ID/EX register, the execute stage and the memory stage.
// slave = execute stage; master = the driver of ID/EX plus the memory-stage observer.
interface ex_stage_if #(
    parameter int XLEN = 32
);
    logic            valid_in;
    logic            reg_write_in;
    logic            mem_to_reg_in;
    logic            mem_write_in;
    logic            mem_read_in;
    logic            branch_in;
    logic            alu_src_in;
    logic [1:0]      alu_op_in;
    logic [4:0]      rd_in;
    logic [XLEN-1:0] nextpc_in;
    logic [XLEN-1:0] rs_data_in;
    logic [XLEN-1:0] rt_data_in;
    logic [XLEN-1:0] imm_in;
    logic            flush_in;
    logic            mem_stall_in;

    logic            stall_out;
    logic            valid_out;
    logic            reg_write_out;
    logic            mem_to_reg_out;
    logic            mem_write_out;
    logic            mem_read_out;
    logic [4:0]      rd_out;
    logic [XLEN-1:0] alu_result_out;
    logic [XLEN-1:0] store_data_out;
    logic            branch_taken_out;
    logic [XLEN-1:0] branch_target_out;

    modport master (
        output valid_in, reg_write_in, mem_to_reg_in, mem_write_in, mem_read_in,
               branch_in, alu_src_in, alu_op_in, rd_in, nextpc_in, rs_data_in,
               rt_data_in, imm_in, flush_in, mem_stall_in,
        input  stall_out, valid_out, reg_write_out, mem_to_reg_out, mem_write_out,
               mem_read_out, rd_out, alu_result_out, store_data_out,
               branch_taken_out, branch_target_out
    );

    modport slave (
        input  valid_in, reg_write_in, mem_to_reg_in, mem_write_in, mem_read_in,
               branch_in, alu_src_in, alu_op_in, rd_in, nextpc_in, rs_data_in,
               rt_data_in, imm_in, flush_in, mem_stall_in,
        output stall_out, valid_out, reg_write_out, mem_to_reg_out, mem_write_out,
               mem_read_out, rd_out, alu_result_out, store_data_out,
               branch_taken_out, branch_target_out
    );
endinterface

// File: rtl/ex_stage.sv
// Execute stage: ALU, branch resolve, iterative shift-add multiply and the EX/MEM register.
// MUL_CYCLES must equal XLEN so the multiplier consumes every bit of operand B.
module ex_stage #(
    parameter int XLEN       = 32,
    parameter int MUL_CYCLES = 32
) (
    input  logic        clk,
    input  logic        reset,
    ex_stage_if.slave   bus
);
    localparam int CW = (MUL_CYCLES > 1) ? $clog2(MUL_CYCLES) : 1;

    typedef enum logic [1:0] {IDLE, MUL_BUSY, MUL_DONE} state_e;

    typedef struct packed {
        logic            valid;
        logic            reg_write;
        logic            mem_to_reg;
        logic            mem_write;
        logic            mem_read;
        logic [4:0]      rd;
        logic [XLEN-1:0] alu_result;
        logic [XLEN-1:0] store_data;
        logic            br_taken;
        logic [XLEN-1:0] br_target;
    } exmem_t;

    state_e          state_q, state_d;
    exmem_t          exmem_q, exmem_d, live;
    logic [XLEN-1:0] mul_a_q, mul_a_d, mul_b_q, mul_b_d, acc_q, acc_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [XLEN-1:0] op_b, alu_res;
    logic [5:0]      funct;
    logic            is_mul, mul_req;

    assign op_b    = bus.alu_src_in ? bus.imm_in : bus.rt_data_in;
    assign funct   = bus.imm_in[5:0];
    assign is_mul  = (bus.alu_op_in == 2'b10) && (funct == 6'h18);
    assign mul_req = bus.valid_in && is_mul;

    always_comb begin
        alu_res = '0;
        case (bus.alu_op_in)
            2'b00: alu_res = bus.rs_data_in + op_b;
            2'b01: alu_res = bus.rs_data_in - op_b;
            2'b10: begin
                case (funct)
                    6'h20: alu_res = bus.rs_data_in + op_b;
                    6'h22: alu_res = bus.rs_data_in - op_b;
                    6'h24: alu_res = bus.rs_data_in & op_b;
                    6'h25: alu_res = bus.rs_data_in | op_b;
                    6'h27: alu_res = ~(bus.rs_data_in | op_b);
                    6'h2A: alu_res = {{(XLEN-1){1'b0}},
                                      ($signed(bus.rs_data_in) < $signed(op_b))};
                    default: alu_res = '0;
                endcase
            end
            default: alu_res = '0;
        endcase
    end

    // EX/MEM image of the instruction currently held in ID/EX; alu_result filled per state.
    always_comb begin
        live            = '0;
        live.valid      = 1'b1;
        live.reg_write  = bus.reg_write_in;
        live.mem_to_reg = bus.mem_to_reg_in;
        live.mem_write  = bus.mem_write_in;
        live.mem_read   = bus.mem_read_in;
        live.rd         = bus.rd_in;
        live.store_data = bus.rt_data_in;
        live.br_taken   = bus.branch_in && (bus.rs_data_in == bus.rt_data_in);
        live.br_target  = bus.nextpc_in + (bus.imm_in << 2);
    end

    always_comb begin
        state_d = state_q;
        exmem_d = exmem_q;
        mul_a_d = mul_a_q;
        mul_b_d = mul_b_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        if (bus.flush_in) begin
            state_d = IDLE;
            exmem_d = '0;
        end else if (!bus.mem_stall_in) begin
            case (state_q)
                IDLE: begin
                    exmem_d = '0;
                    if (mul_req) begin
                        mul_a_d = bus.rs_data_in;
                        mul_b_d = op_b;
                        acc_d   = '0;
                        cnt_d   = '0;
                        state_d = MUL_BUSY;
                    end else if (bus.valid_in) begin
                        exmem_d            = live;
                        exmem_d.alu_result = alu_res;
                    end
                end
                MUL_BUSY: begin
                    exmem_d = '0;
                    acc_d   = mul_b_q[0] ? (acc_q + mul_a_q) : acc_q;
                    mul_a_d = mul_a_q << 1;
                    mul_b_d = mul_b_q >> 1;
                    cnt_d   = cnt_q + CW'(1);
                    if (cnt_q == CW'(MUL_CYCLES - 1))
                        state_d = MUL_DONE;
                end
                MUL_DONE: begin
                    exmem_d            = live;
                    exmem_d.alu_result = acc_q;
                    state_d            = IDLE;
                end
                default: state_d = IDLE;
            endcase
        end
    end

    // A flush overrides the multiply's hold; only the memory stage can still stall then.
    assign bus.stall_out = !reset && (bus.mem_stall_in ||
                           (!bus.flush_in && ((state_q == MUL_BUSY) ||
                                              ((state_q == IDLE) && mul_req))));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            exmem_q <= '0;
            mul_a_q <= '0;
            mul_b_q <= '0;
            acc_q   <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            exmem_q <= exmem_d;
            mul_a_q <= mul_a_d;
            mul_b_q <= mul_b_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
        end
    end

    assign bus.valid_out         = exmem_q.valid;
    assign bus.reg_write_out     = exmem_q.reg_write;
    assign bus.mem_to_reg_out    = exmem_q.mem_to_reg;
    assign bus.mem_write_out     = exmem_q.mem_write;
    assign bus.mem_read_out      = exmem_q.mem_read;
    assign bus.rd_out            = exmem_q.rd;
    assign bus.alu_result_out    = exmem_q.alu_result;
    assign bus.store_data_out    = exmem_q.store_data;
    assign bus.branch_taken_out  = exmem_q.br_taken;
    assign bus.branch_target_out = exmem_q.br_target;
endmodule
